// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among
// NUM_REQ byte requesters, with packet lock and a start timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 is_transmitting,
  output logic                 busy,
  output logic [15:0]          bytes_sent,
  output logic                 timeout_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (START_TIMEOUT > 1) ?
                      $clog2(START_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t             state, state_d;
  logic [IW-1:0]      rr_ptr, rr_ptr_d;
  logic [IW-1:0]      gidx, gidx_d;
  logic               gvld, gvld_d;
  logic               last_flag, last_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               tx_start_d;
  logic [7:0]         tx_data_d;
  logic [15:0]        bytes_d;
  logic               terr_d;
  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic [7:0]         byte_of [NUM_REQ];

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] a,
    input int            b
  );
    return IW'((int'(a) + b) % NUM_REQ);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign byte_of[i] = req_data[8*i +: 8];
  end

  assign grant = gvld ? (NUM_REQ'(1) << gidx) : '0;
  assign busy  = (state != IDLE);

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[wrap(rr_ptr, i)]) begin
        win_vld = 1'b1;
        win_idx = wrap(rr_ptr, i);
      end
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    gidx_d     = gidx;
    gvld_d     = gvld;
    last_d     = last_flag;
    cnt_d      = cnt;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    bytes_d    = bytes_sent;
    terr_d     = timeout_err;
    unique case (state)
      IDLE: begin
        if (!is_transmitting && win_vld) begin
          gidx_d  = win_idx;
          gvld_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (req[gidx]) begin
          tx_data_d  = byte_of[gidx];
          tx_start_d = 1'b1;
          ack_d      = NUM_REQ'(1) << gidx;
          last_d     = req_last[gidx];
          cnt_d      = CW'(START_TIMEOUT);
          state_d    = WAIT_START;
        end else begin
          gvld_d   = 1'b0;
          rr_ptr_d = wrap(gidx, 1);
          state_d  = IDLE;
        end
      end
      WAIT_START: begin
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (cnt <= CW'(1)) begin
          terr_d   = 1'b1;
          gvld_d   = 1'b0;
          rr_ptr_d = wrap(gidx, 1);
          state_d  = IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          bytes_d = bytes_sent + 16'd1;
          // mid-packet: keep the grant and go straight back
          if (last_flag) begin
            gvld_d   = 1'b0;
            rr_ptr_d = wrap(gidx, 1);
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      gvld        <= 1'b0;
      last_flag   <= 1'b0;
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      bytes_sent  <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      gidx        <= gidx_d;
      gvld        <= gvld_d;
      last_flag   <= last_d;
      cnt         <= cnt_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      bytes_sent  <= bytes_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester
// queues and a behavioural UART busy model.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        is_transmitting;
  logic        busy;
  logic [15:0] bytes_sent;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] e;
  logic [8:0]  rmem [4][8];
  int          rh[4] = '{0, 0, 0, 0};
  int          rt[4] = '{0, 0, 0, 0};

  int   uart_cnt = 0;
  int   uart_len = 4;
  logic uart_en  = 1'b1;

  int        since_tx = 100;
  logic [3:0] prev_grant = 4'h0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .START_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .grant(grant),
    .ack(ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .is_transmitting(is_transmitting),
    .busy(busy),
    .bytes_sent(bytes_sent),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign is_transmitting = (uart_cnt != 0);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, want);
    end
  endtask

  task automatic drive_reqs();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      h = rmem[i][rh[i] % 8];
      req[i] = (rh[i] != rt[i]);
      req_data[8*i +: 8] = req[i] ? h[7:0] : 8'h00;
      req_last[i] = req[i] & h[8];
    end
  endtask

  task automatic load(
    input int         r,
    input logic [7:0] d,
    input logic       l
  );
    rmem[r][rt[r] % 8] = {l, d};
    rt[r]++;
    drive_reqs();
  endtask

  task automatic push(input int r, input logic [7:0] d);
    exp_q.push_back({4'(1 << r), d});
  endtask

  function automatic int pend();
    int s = 0;
    for (int i = 0; i < 4; i++) s += rt[i] - rh[i];
    return s;
  endfunction

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0 || pend() != 0 ||
                is_transmitting) && n < 400);
    if (n >= 400)
      chk("idle_to", 32'(exp_q.size()) + 32'(busy), 0);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(tag, 32'(tx_start), 1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_grant"}, 32'(grant), 0);
    chk({p, "_ack"}, 32'(ack), 0);
    chk({p, "_txs"}, 32'(tx_start), 0);
    chk({p, "_txd"}, 32'(tx_data), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_bytes"}, 32'(bytes_sent), 0);
    chk({p, "_terr"}, 32'(timeout_err), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // UART: busy for uart_len cycles after each tx_start
  always @(negedge clk) begin
    if (uart_cnt > 0) uart_cnt--;
    if (tx_start === 1'b1 && uart_en) uart_cnt = uart_len;
  end

  // requesters pop their head byte on ack
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ack[i] === 1'b1 && rh[i] != rt[i]) rh[i]++;
    drive_reqs();
  end

  always @(negedge clk) begin
    since_tx++;
    if (tx_start === 1'b1) begin
      chk("tx_gap", 32'(since_tx >= 3), 1);
      chk("grant_hold", 32'(grant), 32'(prev_grant));
      chk("ack_grant", 32'(ack), 32'(grant));
      if (exp_q.size() == 0) begin
        chk("sb_extra", 32'(grant), 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", 32'(grant), 32'(e[11:8]));
        chk("sb_data", 32'(tx_data), 32'(e[7:0]));
      end
      since_tx = 0;
    end
    prev_grant = grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] seen;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("rst0");

    // single byte
    load(0, 8'h41, 1'b1);
    push(0, 8'h41);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 4'h0 && n < 20);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_pre", 32'(tx_start), 0);
    @(negedge clk);
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_ack", 32'(ack), 32'h1);
    wait_idle();
    chk("t1_bytes", 32'(bytes_sent), 1);
    chk("t1_rel", 32'(grant), 0);

    // round robin from a fresh pointer
    pulse_rst();
    load(0, 8'hA0, 1'b1);
    load(0, 8'hA1, 1'b1);
    load(1, 8'hB0, 1'b1);
    load(2, 8'hC0, 1'b1);
    load(3, 8'hD0, 1'b1);
    push(0, 8'hA0);
    push(1, 8'hB0);
    push(2, 8'hC0);
    push(3, 8'hD0);
    push(0, 8'hA1);
    wait_idle();
    chk("rr_bytes", 32'(bytes_sent), 5);

    // packet lock: 1 holds the UART for 3 bytes
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b0);
    load(1, 8'h13, 1'b1);
    load(2, 8'h21, 1'b1);
    push(1, 8'h11);
    push(1, 8'h12);
    push(1, 8'h13);
    push(2, 8'h21);
    wait_idle();
    chk("pl_bytes", 32'(bytes_sent), 9);

    // start timeout
    uart_en = 1'b0;
    load(3, 8'h5A, 1'b1);
    push(3, 8'h5A);
    wait_tx("to_tx");
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 15);
    chk("to_flag", 32'(timeout_err), 1);
    chk("to_grant", 32'(grant), 0);
    chk("to_bytes", 32'(bytes_sent), 9);
    @(negedge clk);
    chk("to_idle", 32'(busy), 0);
    chk("to_sticky", 32'(timeout_err), 1);
    uart_en = 1'b1;

    // reset while a byte is inside the UART
    uart_len = 20;
    load(0, 8'h77, 1'b1);
    push(0, 8'h77);
    wait_tx("rm_tx");
    repeat (3) @(negedge clk);
    chk("rm_busy", 32'(busy), 1);
    chk("rm_uart", 32'(is_transmitting), 1);
    rst = 1'b1;
    load(1, 8'h99, 1'b1);
    push(1, 8'h99);
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rm");
    seen = 4'h0;
    n = 0;
    while (is_transmitting && n < 60) begin
      seen |= grant;
      @(negedge clk);
      n++;
    end
    chk("rm_nogrant", 32'(seen), 0);
    chk("rm_fell", 32'(is_transmitting), 0);
    wait_idle();
    chk("rm_bytes", 32'(bytes_sent), 1);

    // counter wrap
    uart_len = 3;
    force dut.bytes_sent = 16'hFFFE;
    @(negedge clk);
    release dut.bytes_sent;
    @(negedge clk);
    chk("wr_pre", 32'(bytes_sent), 32'hFFFE);
    load(2, 8'h10, 1'b1);
    push(2, 8'h10);
    wait_idle();
    chk("wr_ffff", 32'(bytes_sent), 32'hFFFF);
    load(3, 8'h20, 1'b1);
    push(3, 8'h20);
    wait_idle();
    chk("wr_zero", 32'(bytes_sent), 0);

    chk("sb_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
